// File: rtl/adpll_tdc_pkg.sv
// Shared definitions for the ADPLL TDC decoder slice:
//   - calibration FSM state type
//   - default geometry constants
//   - accumulator sizing helper
package adpll_tdc_pkg;

    // state | meaning
    // CAL   | collecting half-period samples, tdc_half_period not yet valid
    // RUN   | average published, holding until recal
    typedef enum logic {
        CAL = 1'b0,
        RUN = 1'b1
    } cal_state_e;

    localparam int DEF_TAPS     = 32;
    localparam int DEF_CAL_LOG2 = 4;

    // The sum of 2^cal_log2 samples, each at most 2^(idx_w+1)-1, fits without overflow.
    function automatic int acc_width(input int idx_w, input int cal_log2);
        return idx_w + 1 + cal_log2;
    endfunction

endpackage

// File: rtl/adpll_tdc_edge_find.sv
// Combinational priority search for the first transition of one polarity
// in a thermometer vector. RISING=1 looks for 0->1, RISING=0 for 1->0.
// The index returned is the position of the upper tap of the pair; it is 0
// when no transition exists.
module adpll_tdc_edge_find
    import adpll_tdc_pkg::*;
#(
    parameter int TAPS   = DEF_TAPS,
    parameter int IDX_W  = $clog2(TAPS),
    parameter bit RISING = 1'b1
) (
    input  logic [TAPS-1:0]  vec,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    // Scan from the top down so that the lowest matching tap wins.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = TAPS - 1; i >= 1; i--) begin
            if (RISING ? (!vec[i-1] && vec[i]) : (vec[i-1] && !vec[i])) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adpll_tdc_decoder.sv
// Thermometer-to-binary decoder for the ADPLL TDC.
// Pipeline: S0 capture -> [S1 bubble majority filter] -> S2 edge search/output.
// A calibration FSM averages |fall - rise| over 2^CAL_LOG2 samples to give
// the DCO half-period in taps.
// Build option: TDC_BUBBLE_FIX_EN enables the S1 majority filter
// (latency 3); without it S2 works directly on the captured snapshot (latency 2).
module adpll_tdc_decoder
    import adpll_tdc_pkg::*;
#(
    parameter int TAPS     = DEF_TAPS,
    parameter int IDX_W    = $clog2(TAPS),
    parameter int CAL_LOG2 = DEF_CAL_LOG2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sample_en,
    input  logic [TAPS-1:0]  tdc_therm,
    input  logic             recal,
    output logic             tdc_valid,
    output logic [IDX_W-1:0] tdc_rise,
    output logic [IDX_W-1:0] tdc_fall,
    output logic             tdc_err,
    output logic [IDX_W:0]   tdc_half_period,
    output logic             cal_done
);

    localparam int ACC_W = acc_width(IDX_W, CAL_LOG2);

    logic [TAPS-1:0]     r_s0;
    logic                r_v0;
    logic [TAPS-1:0]     w_edge_vec;
    logic                w_edge_v;
    logic [IDX_W-1:0]    w_rise_idx;
    logic [IDX_W-1:0]    w_fall_idx;
    logic                w_rise_found;
    logic                w_fall_found;
    logic                r_fall_found;
    logic [IDX_W:0]      w_hp;
    logic                w_hp_sample;

    cal_state_e          r_state;
    cal_state_e          w_state_nxt;
    logic [ACC_W-1:0]    r_acc;
    logic [ACC_W-1:0]    w_acc_nxt;
    logic [ACC_W-1:0]    w_sum;
    logic [CAL_LOG2-1:0] r_cnt;
    logic [CAL_LOG2-1:0] w_cnt_nxt;
    logic [IDX_W:0]      w_half_nxt;
    logic                w_done_nxt;

    // S0: capture the snapshot on sample_en; the snapshot register holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s0 <= '0;
            r_v0 <= 1'b0;
        end else begin
            r_v0 <= sample_en;
            if (sample_en) begin
                r_s0 <= tdc_therm;
            end
        end
    end

`ifdef TDC_BUBBLE_FIX_EN
    logic [TAPS-1:0] r_s1;
    logic            r_v1;
    logic [TAPS-1:0] w_below;
    logic [TAPS-1:0] w_above;
    logic [TAPS-1:0] w_maj;

    // Neighbour vectors with the end taps replicated, so the filter never
    // invents an edge at the array boundaries.
    assign w_below = {r_s0[TAPS-2:0], r_s0[0]};
    assign w_above = {r_s0[TAPS-1], r_s0[TAPS-1:1]};
    assign w_maj   = (w_below & r_s0) | (w_below & w_above) | (r_s0 & w_above);

    // S1: register the majority-filtered snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= '0;
            r_v1 <= 1'b0;
        end else begin
            r_v1 <= r_v0;
            if (r_v0) begin
                r_s1 <= w_maj;
            end
        end
    end

    assign w_edge_vec = r_s1;
    assign w_edge_v   = r_v1;
`else
    assign w_edge_vec = r_s0;
    assign w_edge_v   = r_v0;
`endif

    adpll_tdc_edge_find #(
        .TAPS   (TAPS),
        .IDX_W  (IDX_W),
        .RISING (1'b1)
    ) u_rise (
        .vec   (w_edge_vec),
        .idx   (w_rise_idx),
        .found (w_rise_found)
    );

    adpll_tdc_edge_find #(
        .TAPS   (TAPS),
        .IDX_W  (IDX_W),
        .RISING (1'b0)
    ) u_fall (
        .vec   (w_edge_vec),
        .idx   (w_fall_idx),
        .found (w_fall_found)
    );

    // S2: publish edge indices; they hold between valid pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tdc_valid    <= 1'b0;
            tdc_rise     <= '0;
            tdc_fall     <= '0;
            tdc_err      <= 1'b0;
            r_fall_found <= 1'b0;
        end else begin
            tdc_valid <= w_edge_v;
            if (w_edge_v) begin
                tdc_rise     <= w_rise_idx;
                tdc_fall     <= w_fall_idx;
                tdc_err      <= !w_rise_found;
                r_fall_found <= w_fall_found;
            end
        end
    end

    // Half-period candidate from the published edges; only usable when both
    // edges were found and they differ.
    assign w_hp        = (tdc_fall >= tdc_rise) ? {1'b0, tdc_fall - tdc_rise}
                                                : {1'b0, tdc_rise - tdc_fall};
    assign w_hp_sample = tdc_valid && !tdc_err && r_fall_found && (w_hp != '0);
    assign w_sum       = r_acc + ACC_W'(w_hp);

    // Calibration FSM next-state: recal wins over a coincident sample.
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_half_nxt  = tdc_half_period;
        w_done_nxt  = cal_done;
        case (r_state)
            CAL: begin
                if (recal) begin
                    w_acc_nxt = '0;
                    w_cnt_nxt = '0;
                end else if (w_hp_sample) begin
                    if (r_cnt == {CAL_LOG2{1'b1}}) begin
                        w_half_nxt  = w_sum[ACC_W-1:CAL_LOG2];
                        w_done_nxt  = 1'b1;
                        w_acc_nxt   = '0;
                        w_cnt_nxt   = '0;
                        w_state_nxt = RUN;
                    end else begin
                        w_acc_nxt = w_sum;
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            RUN: begin
                if (recal) begin
                    w_acc_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_done_nxt  = 1'b0;
                    w_state_nxt = CAL;
                end
            end
            default: begin
                w_state_nxt = CAL;
                w_acc_nxt   = '0;
                w_cnt_nxt   = '0;
                w_done_nxt  = 1'b0;
            end
        endcase
    end

    // Calibration FSM state and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= CAL;
            r_acc           <= '0;
            r_cnt           <= '0;
            tdc_half_period <= '0;
            cal_done        <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_acc           <= w_acc_nxt;
            r_cnt           <= w_cnt_nxt;
            tdc_half_period <= w_half_nxt;
            cal_done        <= w_done_nxt;
        end
    end

endmodule

// File: tb/tb_adpll_tdc_decoder.sv
// Self-checking bench for adpll_tdc_decoder (TAPS=32, CAL_LOG2=2).
// Expected outputs come from a cycle-level behavioural model: a queue of
// pending snapshots with due times, a plain bit-array edge search and a
// list of half-period samples averaged arithmetically.
module tb_adpll_tdc_decoder;

    localparam int TAPS  = 32;
    localparam int IDX_W = 5;
    localparam int CL2   = 2;
    localparam int CAL_N = 4;
`ifdef TDC_BUBBLE_FIX_EN
    localparam int LAT = 3;
    localparam bit BUB = 1'b1;
`else
    localparam int LAT = 2;
    localparam bit BUB = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             sample_en = 1'b0;
    logic [TAPS-1:0]  tdc_therm = '0;
    logic             recal = 1'b0;
    logic             tdc_valid;
    logic [IDX_W-1:0] tdc_rise;
    logic [IDX_W-1:0] tdc_fall;
    logic             tdc_err;
    logic [IDX_W:0]   tdc_half_period;
    logic             cal_done;

    adpll_tdc_decoder #(
        .TAPS     (TAPS),
        .IDX_W    (IDX_W),
        .CAL_LOG2 (CL2)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .sample_en       (sample_en),
        .tdc_therm       (tdc_therm),
        .recal           (recal),
        .tdc_valid       (tdc_valid),
        .tdc_rise        (tdc_rise),
        .tdc_fall        (tdc_fall),
        .tdc_err         (tdc_err),
        .tdc_half_period (tdc_half_period),
        .cal_done        (cal_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        logic [31:0] th;
    } ev_t;

    ev_t  pend[$];
    int   hp_list[$];
    int   ecount = 0;
    logic exp_valid = 0, exp_err = 0, exp_done = 0;
    int   exp_rise = 0, exp_fall = 0, exp_hp = 0;
    bit   in_run = 0;
    bit   prev_hp_ok = 0;
    int   prev_hp_val = 0;

    task automatic decode(input logic [31:0] th, output int r, output int f,
                          output bit rf, output bit ff);
        int c[TAPS];
        for (int i = 0; i < TAPS; i++) begin
            if (BUB) begin
                int lo, hi;
                lo = (i == 0) ? int'(th[0]) : int'(th[i-1]);
                hi = (i == TAPS - 1) ? int'(th[TAPS-1]) : int'(th[i+1]);
                c[i] = ((lo + int'(th[i]) + hi) >= 2) ? 1 : 0;
            end else begin
                c[i] = int'(th[i]);
            end
        end
        r = 0; f = 0; rf = 0; ff = 0;
        for (int i = 1; i < TAPS; i++) begin
            if (!rf && c[i-1] == 0 && c[i] == 1) begin r = i; rf = 1; end
            if (!ff && c[i-1] == 1 && c[i] == 0) begin f = i; ff = 1; end
        end
    endtask

    task automatic model_edge(input logic se, input logic [31:0] th, input logic rc);
        int r, f, s;
        bit rf, ff;
        ev_t ev;
        ecount++;
        if (rc) begin
            hp_list.delete();
            exp_done = 0;
            in_run   = 0;
        end else if (prev_hp_ok && !in_run) begin
            hp_list.push_back(prev_hp_val);
            if (hp_list.size() == CAL_N) begin
                s = 0;
                foreach (hp_list[k]) s += hp_list[k];
                exp_hp   = s / CAL_N;
                exp_done = 1;
                in_run   = 1;
                hp_list.delete();
            end
        end
        exp_valid  = 0;
        prev_hp_ok = 0;
        if (pend.size() > 0 && pend[0].due == ecount) begin
            ev = pend.pop_front();
            decode(ev.th, r, f, rf, ff);
            exp_valid = 1;
            exp_rise  = r;
            exp_fall  = f;
            exp_err   = !rf;
            if (rf && ff && r != f) begin
                prev_hp_ok  = 1;
                prev_hp_val = (r > f) ? r - f : f - r;
            end
        end
        if (se) begin
            ev.due = ecount + LAT - 1;
            ev.th  = th;
            pend.push_back(ev);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        hp_list.delete();
        exp_valid = 0; exp_err = 0; exp_done = 0;
        exp_rise = 0; exp_fall = 0; exp_hp = 0;
        in_run = 0; prev_hp_ok = 0;
    endtask

    task automatic check_all(input string pfx);
        check_val({pfx, "_valid"}, tdc_valid, exp_valid);
        check_val({pfx, "_rise"},  tdc_rise, exp_rise);
        check_val({pfx, "_fall"},  tdc_fall, exp_fall);
        check_val({pfx, "_err"},   tdc_err, exp_err);
        check_val({pfx, "_hp"},    tdc_half_period, exp_hp);
        check_val({pfx, "_done"},  cal_done, exp_done);
    endtask

    // One clock: drive inputs, advance the model at the edge, check at negedge.
    task automatic cycle(input logic se, input logic [31:0] th, input logic rc, input string pfx);
        sample_en = se;
        tdc_therm = th;
        recal     = rc;
        @(posedge clk);
        model_edge(se, th, rc);
        @(negedge clk);
        check_all(pfx);
    endtask

    task automatic idle(input int n, input string pfx);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b0, pfx);
    endtask

    function automatic logic [31:0] rand_therm();
        logic [31:0] v;
        int a, b, k;
        k = $urandom_range(0, 4);
        v = '0;
        case (k)
            0: v = $urandom();
            1, 2: begin
                a = $urandom_range(0, 31);
                b = $urandom_range(a, 31);
                for (int i = a; i <= b; i++) v[i] = 1'b1;
                if (k == 2) v[$urandom_range(0, 31)] ^= 1'b1;
            end
            3: v = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'h0;
            default: v = 32'h0000_FF00 << $urandom_range(0, 8);
        endcase
        return v;
    endfunction

    initial begin
        // reset
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        check_all("reset");
        rst_n = 1'b1;

        // clean snapshot
        cycle(1'b1, 32'h0000_FF00, 1'b0, "clean");
        idle(LAT - 1, "clean");
        check_val("clean_valid_n", tdc_valid, 1'b1);
        check_val("clean_rise_8", tdc_rise, 8);
        check_val("clean_fall_16", tdc_fall, 16);
        check_val("clean_err_0", tdc_err, 0);

        // single-tap bubble
        cycle(1'b1, 32'h0000_FB00, 1'b0, "bubble");
        idle(LAT - 1, "bubble");
        check_val("bubble_rise_8", tdc_rise, 8);
`ifdef TDC_BUBBLE_FIX_EN
        check_val("bubble_fall", tdc_fall, 16);
`else
        check_val("bubble_fall", tdc_fall, 10);
`endif

        // no rising edge: all zeros, all ones
        cycle(1'b1, 32'h0000_0000, 1'b0, "zeros");
        idle(LAT - 1, "zeros");
        check_val("zeros_err_1", tdc_err, 1);
        check_val("zeros_rise_0", tdc_rise, 0);
        check_val("zeros_fall_0", tdc_fall, 0);
        cycle(1'b1, 32'hFFFF_FFFF, 1'b0, "ones");
        idle(LAT - 1, "ones");
        check_val("ones_err_1", tdc_err, 1);
        idle(2, "ones");

        // calibration 8,8,10,10 -> 9
        cycle(1'b0, 32'h0, 1'b1, "cal");
        cycle(1'b1, 32'h0000_FF00, 1'b0, "cal");
        cycle(1'b1, 32'h0000_0000, 1'b0, "cal");
        cycle(1'b1, 32'h0000_FF00, 1'b0, "cal");
        cycle(1'b1, 32'h0003_FF00, 1'b0, "cal");
        cycle(1'b1, 32'h0003_FF00, 1'b0, "cal");
        idle(LAT + 1, "cal");
        check_val("cal_hp_9", tdc_half_period, 9);
        check_val("cal_done_1", cal_done, 1);
        cycle(1'b0, 32'h0, 1'b1, "recal");
        check_val("recal_done_0", cal_done, 0);

        // streaming: 8 back-to-back snapshots
        for (int i = 0; i < 8; i++) cycle(1'b1, rand_therm(), 1'b0, "stream");
        idle(LAT, "stream");

        // reset mid-pipeline
        cycle(1'b1, 32'h0000_FF00, 1'b0, "prerst");
        rst_n = 1'b0;
        sample_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        model_reset();
        check_all("midrst");
        rst_n = 1'b1;
        idle(LAT + 1, "postrst");
        // FSM restarted in CAL from empty accumulator
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'h0000_FF00, 1'b0, "postcal");
        idle(LAT + 1, "postcal");
        check_val("postrst_hp_8", tdc_half_period, 8);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 9) < 7), rand_therm(),
                  ($urandom_range(0, 39) == 0), "rand");
        end
        idle(LAT + 1, "tail");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
